// File: rtl/req_ack_responder.sv
// Responder end of a 4-phase req/ack handshake. It presents captured req_data on a
// valid/ready stage and counts completed transfers. Define REQ_SYNC_EN to pass req through a 2-flop synchronizer.
module req_ack_responder #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [DATA_W-1:0] req_data,
  output logic              ack,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  xfer_cnt,
  output logic              proto_err
);

  typedef enum logic [1:0] {IDLE, VALID, ACK} state_t;

  state_t            state, state_nx;
  logic              ack_nx, out_valid_nx, proto_err_nx;
  logic [DATA_W-1:0] out_data_nx;
  logic [CNT_W-1:0]  xfer_cnt_nx;
  logic              req_s;

`ifdef REQ_SYNC_EN
  logic req_meta, req_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_meta <= 1'b0;
      req_sync <= 1'b0;
    end else begin
      req_meta <= req;
      req_sync <= req_meta;
    end
  end

  assign req_s = req_sync;
`else
  assign req_s = req;
`endif

  // busy is registered from the next state so it tracks state exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ack       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      xfer_cnt  <= '0;
      proto_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      ack       <= ack_nx;
      out_valid <= out_valid_nx;
      out_data  <= out_data_nx;
      xfer_cnt  <= xfer_cnt_nx;
      proto_err <= proto_err_nx;
      busy      <= (state_nx != IDLE);
    end
  end

  always_comb begin
    state_nx     = state;
    ack_nx       = ack;
    out_valid_nx = out_valid;
    out_data_nx  = out_data;
    xfer_cnt_nx  = xfer_cnt;
    proto_err_nx = proto_err;
    case (state)
      IDLE: begin
        if (req_s) begin
          out_data_nx  = req_data;
          out_valid_nx = 1'b1;
          state_nx     = VALID;
        end
      end
      VALID: begin
        // A dropped request wins over a simultaneous consumer accept.
        if (!req_s) begin
          out_valid_nx = 1'b0;
          proto_err_nx = 1'b1;
          state_nx     = IDLE;
        end else if (out_ready) begin
          out_valid_nx = 1'b0;
          ack_nx       = 1'b1;
          xfer_cnt_nx  = xfer_cnt + CNT_W'(1);
          state_nx     = ACK;
        end
      end
      ACK: begin
        if (!req_s) begin
          ack_nx   = 1'b0;
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx     = IDLE;
        ack_nx       = 1'b0;
        out_valid_nx = 1'b0;
      end
    endcase
  end

endmodule
